// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit
// Description : Front-end fetch stage of the 16-bit CPU. Holds the program
//               counter, drives the word address to a combinational
//               instruction memory and registers the returned word into the
//               IF/ID pipeline register. Handles stall, branch/jump redirect
//               with flush, and HALT detection, which freezes fetch until a
//               redirect or reset.
//
// Parameters  : RESET_PC     - PC value loaded on reset
//               HALT_OPCODE  - instr[15:12] value that halts fetch
//
// Ports       : clk            - system clock, rising edge
//               rst_n          - asynchronous active-low reset
//               imem_addr      - word address to instruction memory (= pc)
//               imem_instr     - instruction word for imem_addr, same cycle
//               stall          - hold PC and IF/ID register
//               redirect_valid - taken branch/jump
//               redirect_pc    - redirect target word address
//               pc             - current fetch address
//               if_valid       - IF/ID register holds a real instruction
//               if_instr       - latched instruction, zero when invalid
//               if_pc          - address of if_instr
//               halted         - fetch frozen in the HALTED state
//
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'b1111
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_instr,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic [15:0] pc,
    output logic        if_valid,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc,
    output logic        halted
);

    typedef enum logic [0:0] {
        C_ST_FETCH  = 1'b0,
        C_ST_HALTED = 1'b1
    } state_t;

    state_t      r_state;
    logic [15:0] r_pc;
    logic        r_if_valid;
    logic [15:0] r_if_instr;
    logic [15:0] r_if_pc;

    logic        w_is_halt;

    assign w_is_halt = (imem_instr[15:12] == HALT_OPCODE);

    // Priority on every edge: redirect > stall > normal progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= C_ST_FETCH;
            r_pc       <= RESET_PC;
            r_if_valid <= 1'b0;
            r_if_instr <= 16'h0000;
            r_if_pc    <= 16'h0000;
        end else if (redirect_valid) begin
            // Load target and flush IF/ID; also squashes a wrong-path HALT.
            r_state    <= C_ST_FETCH;
            r_pc       <= redirect_pc;
            r_if_valid <= 1'b0;
            r_if_instr <= 16'h0000;
            r_if_pc    <= 16'h0000;
        end else if (!stall) begin
            case (r_state)
                C_ST_FETCH: begin
                    r_if_instr <= imem_instr;
                    r_if_pc    <= r_pc;
                    r_if_valid <= 1'b1;
                    if (w_is_halt) begin
                        // PC stays on the HALT address.
                        r_state <= C_ST_HALTED;
                    end else begin
                        // Modulo-2^16 increment: 16'hFFFF wraps to 16'h0000.
                        r_pc <= r_pc + 16'd1;
                    end
                end
                C_ST_HALTED: begin
                    // Let the HALT word drain once, then present bubbles.
                    r_if_valid <= 1'b0;
                    r_if_instr <= 16'h0000;
                end
                default: begin
                    r_state <= C_ST_FETCH;
                end
            endcase
        end
    end

    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign if_valid  = r_if_valid;
    assign if_instr  = r_if_instr;
    assign if_pc     = r_if_pc;
    assign halted    = (r_state == C_ST_HALTED);

endmodule
`default_nettype wire

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Front-end fetch stage of the 16-bit CPU; acts as the initiator to the instruction memory. Holds the program counter and drives the word address to instruction memory, whose read is combinational. Registers the returned word into the IF/ID pipeline register. Handles stall, branch/jump redirect with flush, and HALT (opcode 4'b1111) detection, freezing fetch until a redirect or reset.

## Interface
- `RESET_PC`, 16'h0000, PC value loaded on reset.
- `HALT_OPCODE`, 4'b1111, value of `instr[15:12]` that halts fetch.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  reset; one clock, asynchronous, active-low.
- `imem_addr`  output  16  word address to instruction memory; equals `pc` combinationally.
- `imem_instr`  input  16  instruction word for `imem_addr`, valid in the same cycle.
- `stall`  input  1  hold PC and IF/ID register; from hazard unit.
- `redirect_valid`  input  1  taken branch/jump.
- `redirect_pc`  input  16  target word address.
- `pc`  output  16  current fetch address.
- `if_valid`  output  1  IF/ID register holds a real instruction.
- `if_instr`  output  16  latched instruction; 16'h0000 when invalid.
- `if_pc`  output  16  address of `if_instr`.
- `halted`  output  1  fetch is frozen in the HALTED state.

## Operation
- **Two states**: FETCH and HALTED.
- **Reset** (asynchronous, `rst_n`=0):
  - State goes to FETCH.
  - `pc`=`RESET_PC`, `if_valid`=0, `if_instr`=0, `if_pc`=0, `halted`=0.
- **Priority each edge**: redirect > stall > normal fetch.
- **FETCH, `redirect_valid`=1** (regardless of `stall`):
  - `pc`<=`redirect_pc`.
  - Flush: `if_valid`<=0, `if_instr`<=0, `if_pc`<=0.
  - Stay in FETCH.
- **FETCH, `stall`=1, no redirect**: `pc` and all `if_*` hold.
- **FETCH, normal**:
  - `if_instr`<=`imem_instr`, `if_pc`<=`pc`, `if_valid`<=1.
  - If `imem_instr[15:12]`==`HALT_OPCODE`: `pc` holds, and the state goes to HALTED.
  - Otherwise `pc`<=`pc`+1.
- **HALTED**:
  - `halted`=1 and `pc` is frozen at the HALT address.
  - First non-stalled edge: `if_valid`<=0 and `if_instr`<=0; the HALT drains exactly once.
  - While `stall`=1: the IF/ID register holds the HALT word.
  - `redirect_valid`=1 (squashes a HALT fetched on the wrong path): same flush and `pc` load as in FETCH, and the state returns to FETCH.
  - Otherwise only reset leaves HALTED.
- **Arithmetic**:
  - `pc`+1 is modulo 2^16; 16'hFFFF wraps to 16'h0000.
  - The full 16-bit `pc` drives `imem_addr`; the memory decodes its own low bits.

## Timing
- Memory read is zero-wait: the `pc`→`if_instr` latency is 1 clock.
- Steady state gives 1 instruction per cycle.
- Redirect penalty: 1 bubble (`if_valid`=0 for one cycle). The target instruction appears in `if_*` on the second edge after the redirect.
- `halted` is registered: it rises on the same edge that latches the HALT word into `if_instr`.
- `stall` and `redirect_valid` are sampled only on rising edges. They must be stable for setup before the edge.
- Reset mid-operation:
  - Outputs go to their reset values immediately on `rst_n` fall, not at the next edge.
  - The first fetch of `RESET_PC` is latched on the first edge after `rst_n` rises.

## Test plan
- **Program run.** Memory holds 0x0298 at 0, 0x5805 at 1, 0xF000 at 2; release reset.
  - `if_pc`/`if_instr` show 0/0x0298, then 1/0x5805, then 2/0xF000.
  - `halted`=1 with the HALT latch.
  - `pc` stays at 2.
  - `if_valid`=0 one cycle later and stays 0.
- **Stall.** Assert `stall` for 3 cycles after `if_pc`=1.
  - `pc`=2 and `if_pc`=1 hold for all 3 cycles.
  - Fetch resumes with `if_pc`=2 on the edge after `stall` drops.
- **Redirect with stall.** Assert `redirect_valid`=1, `redirect_pc`=0x0040 together with `stall`=1.
  - Next cycle: `pc`=0x0040 and `if_valid`=0.
  - Following cycle: `if_pc`=0x0040 with `if_valid`=1.
- **Wrap.** Redirect to 0xFFFF with a non-HALT word there.
  - After fetching 0xFFFF: `pc`=0x0000 and `imem_addr`=0x0000.
- **Redirect out of HALTED.** While `halted`=1, redirect to 0x0010.
  - Next cycle: `halted`=0 and `pc`=0x0010.
  - Then `if_pc`=0x0010 with `if_valid`=1.
- **Async reset.** Drop `rst_n` between edges while `pc`=0x0123.
  - Immediately: `pc`=`RESET_PC`, `if_valid`=0, `halted`=0, with no clock edge required.
